// File: rtl/mem_rd_rr_arbiter_pkg.sv
// Shared definitions for the read-request arbiter: default geometry, ID width helpers
// and the request/AR record layouts at the default geometry.
package mem_rd_rr_arbiter_pkg;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 512;
   localparam int DEF_LEN_W     = 8;
   localparam int DEF_TAG_W     = 3;
   localparam int DEF_MAX_OUTST = 4;

   // Channel index width never collapses to zero, even for a single channel.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int id_w(input int n, input int tag_w);
      return ch_w(n) + tag_w;
   endfunction

   localparam int DEF_ID_W = id_w(DEF_NUM_CH, DEF_TAG_W);

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_LEN_W-1:0]  len;
   } req_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_LEN_W-1:0]  len;
      logic [DEF_ID_W-1:0]   id;
   } ar_req_t;

endpackage

// File: rtl/mem_rd_rr_arbiter_if.sv
// Bundle of the per-channel request/response lanes and the merged AR/R pair.
// master = arbiter view, slave = channels plus memory side.
interface mem_rd_rr_arbiter_if
   import mem_rd_rr_arbiter_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int ID_W   = DEF_ID_W
);
   logic [NUM_CH-1:0]        req_valid_i;
   logic [NUM_CH-1:0]        req_ready_o;
   logic [NUM_CH*ADDR_W-1:0] req_addr_i;
   logic [NUM_CH*LEN_W-1:0]  req_len_i;
   logic                     ar_valid_o;
   logic                     ar_ready_i;
   logic [ADDR_W-1:0]        ar_addr_o;
   logic [LEN_W-1:0]         ar_len_o;
   logic [ID_W-1:0]          ar_id_o;
   logic                     r_valid_i;
   logic                     r_ready_o;
   logic [ID_W-1:0]          r_id_i;
   logic [DATA_W-1:0]        r_data_i;
   logic                     r_last_i;
   logic [NUM_CH-1:0]        resp_valid_o;
   logic [NUM_CH-1:0]        resp_ready_i;
   logic [DATA_W-1:0]        resp_data_o;
   logic                     resp_last_o;

   modport master (
      input  req_valid_i, req_addr_i, req_len_i, ar_ready_i,
      input  r_valid_i, r_id_i, r_data_i, r_last_i, resp_ready_i,
      output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_id_o,
      output r_ready_o, resp_valid_o, resp_data_o, resp_last_o
   );

   modport slave (
      output req_valid_i, req_addr_i, req_len_i, ar_ready_i,
      output r_valid_i, r_id_i, r_data_i, r_last_i, resp_ready_i,
      input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_id_o,
      input  r_ready_o, resp_valid_o, resp_data_o, resp_last_o
   );
endinterface

// File: rtl/mem_rd_rr_arbiter_rr_prio_select.sv
// Round-robin priority select: first set request at or after ptr, wrapping at N-1.
// Purely combinational so the write-side arbiter can reuse it.
module mem_rd_rr_arbiter_rr_prio_select #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [PTR_W-1:0] gnt_idx
);
   always_comb begin
      int idx;
      idx       = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      // Walk offsets from far to near so the nearest requester wins last.
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = PTR_W'(idx);
         end
      end
   end
endmodule

// File: rtl/mem_rd_rr_arbiter.sv
// N-channel read-request arbiter: round-robin onto one AR slot with per-channel
// outstanding limits and ID tags, combinational demux of R beats back to channels.
module mem_rd_rr_arbiter
   import mem_rd_rr_arbiter_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int MAX_OUTST = DEF_MAX_OUTST,
   localparam int CH_W     = ch_w(NUM_CH),
   localparam int ID_W     = CH_W + TAG_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mem_rd_rr_arbiter_if.master bus,
   output logic                err_o
);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic [CNT_W-1:0]  cnt_reg [NUM_CH];
   logic [TAG_W-1:0]  tag_reg [NUM_CH];
   logic [CH_W-1:0]   ptr_reg;
   logic              ar_valid_reg;
   logic [ADDR_W-1:0] ar_addr_reg;
   logic [LEN_W-1:0]  ar_len_reg;
   logic [ID_W-1:0]   ar_id_reg;
   logic              err_reg;

   logic [ADDR_W-1:0] ch_addr [NUM_CH];
   logic [LEN_W-1:0]  ch_len  [NUM_CH];
   logic [NUM_CH-1:0] eligible, inc, dec, hit, zero_hit;
   logic [CH_W-1:0]   sel_idx, r_ch;
   logic              sel_valid, slot_free, grant, r_bad;

   assign slot_free = !ar_valid_reg || bus.ar_ready_i;
   assign grant     = slot_free && sel_valid && !rst_i;
   assign r_ch      = bus.r_id_i[ID_W-1:TAG_W];

   // An unknown channel index or a last beat with nothing outstanding is swallowed.
   assign r_bad = bus.r_valid_i && (!(|hit) || (bus.r_last_i && |zero_hit));

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_addr[gi]          = bus.req_addr_i[gi*ADDR_W +: ADDR_W];
         assign ch_len[gi]           = bus.req_len_i[gi*LEN_W +: LEN_W];
         assign eligible[gi]         = bus.req_valid_i[gi] && (int'(cnt_reg[gi]) < MAX_OUTST);
         assign inc[gi]              = grant && (sel_idx == CH_W'(gi));
         assign hit[gi]              = (r_ch == CH_W'(gi));
         assign zero_hit[gi]         = hit[gi] && (cnt_reg[gi] == '0);
         assign dec[gi]              = bus.r_valid_i && hit[gi] && !r_bad && bus.r_last_i
                                       && bus.resp_ready_i[gi];
         assign bus.resp_valid_o[gi] = !rst_i && bus.r_valid_i && hit[gi] && !r_bad;
      end
   endgenerate

   mem_rd_rr_arbiter_rr_prio_select #(
      .N     (NUM_CH),
      .PTR_W (CH_W)
   ) u_sel (
      .req       (eligible),
      .ptr       (ptr_reg),
      .gnt_valid (sel_valid),
      .gnt_idx   (sel_idx)
   );

   assign bus.req_ready_o = inc;
   assign bus.r_ready_o   = r_bad || |(hit & bus.resp_ready_i);
   assign bus.resp_data_o = bus.r_data_i;
   assign bus.resp_last_o = bus.r_last_i;
   assign bus.ar_valid_o  = ar_valid_reg;
   assign bus.ar_addr_o   = ar_addr_reg;
   assign bus.ar_len_o    = ar_len_reg;
   assign bus.ar_id_o     = ar_id_reg;
   assign err_o           = err_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_reg[i] <= '0;
            tag_reg[i] <= '0;
         end
      end else begin
         // A grant and a last beat on the same channel cancel out.
         for (int i = 0; i < NUM_CH; i++) begin
            if (inc[i] && !dec[i])
               cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
            else if (dec[i] && !inc[i])
               cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
            if (inc[i])
               tag_reg[i] <= tag_reg[i] + TAG_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_reg      <= '0;
         ar_valid_reg <= 1'b0;
         ar_addr_reg  <= '0;
         ar_len_reg   <= '0;
         ar_id_reg    <= '0;
         err_reg      <= 1'b0;
      end else begin
         if (grant) begin
            ar_valid_reg <= 1'b1;
            ar_addr_reg  <= ch_addr[sel_idx];
            ar_len_reg   <= ch_len[sel_idx];
            ar_id_reg    <= {sel_idx, tag_reg[sel_idx]};
            ptr_reg      <= (int'(sel_idx) == NUM_CH - 1) ? '0 : sel_idx + CH_W'(1);
         end else if (bus.ar_ready_i) begin
            ar_valid_reg <= 1'b0;
         end
         if (r_bad)
            err_reg <= 1'b1;
      end
   end
endmodule
